// File: rtl/vga_timing_pkg.sv
// Shared timing defaults, saturation limits and FSM encoding for the VGA sync checker.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        StSearch = 2'd0,
        StTrack  = 2'd1,
        StLocked = 2'd2
    } vga_state_e;

    localparam int unsigned HTotalDefault    = 768;
    localparam int unsigned HPulseDefault    = 16;
    localparam int unsigned VTotalDefault    = 512;
    localparam int unsigned LockLinesDefault = 4;

    localparam logic [9:0] CntMax  = 10'h3FF;
    localparam logic [8:0] LineMax = 9'h1FF;

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == CntMax) ? v : v + 10'd1;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Registers one active-low sync input and flags its falling and rising edges.
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sync_in,
    output logic fall,
    output logic rise
);

    logic sync_q;

    // Idle level is high so a low input right after reset reads as a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 1'b1;
        end else begin
            sync_q <= sync_in;
        end
    end

    assign fall = sync_q & ~sync_in;
    assign rise = ~sync_q & sync_in;

endmodule

// File: rtl/vga_sync_checker.sv
// Measures hsync/vsync timing, recovers raster position and tracks lock to the expected
// line, pulse and frame lengths.
module vga_sync_checker
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_TOTAL    = HTotalDefault,
    parameter int unsigned H_PULSE    = HPulseDefault,
    parameter int unsigned V_TOTAL    = VTotalDefault,
    parameter int unsigned LOCK_LINES = LockLinesDefault
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vga_h_sync,
    input  logic       vga_v_sync,
    output logic [9:0] rec_x,
    output logic [8:0] rec_y,
    output logic [9:0] line_len,
    output logic       locked,
    output logic       frame_ok,
    output logic       h_len_err,
    output logic       h_width_err,
    output logic       v_len_err
);

    localparam int unsigned LockW = $clog2(LOCK_LINES + 1);

    logic h_fall, h_rise, v_fall, v_rise;
    logic unused_v_rise;

    vga_state_e state_q, state_d;
    logic [LockW-1:0] lock_cnt_q, lock_cnt_d;
    logic [9:0] rec_x_q, line_len_q, width_q, width_d, vcnt_q, vcnt_d, meas;
    logic [8:0] rec_y_q, rec_y_d;
    logic v_armed_q, v_armed_d, locked_q, frame_ok_q, frame_ok_d;
    logic h_len_err_q, h_width_err_q, v_len_err_q;
    logic x_sat, h_len_bad, h_len_good, v_len_bad, v_len_good, enter_search;

    sync_edge_detect u_h_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .sync_in (vga_h_sync),
        .fall    (h_fall),
        .rise    (h_rise)
    );

    sync_edge_detect u_v_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .sync_in (vga_v_sync),
        .fall    (v_fall),
        .rise    (v_rise)
    );

    assign unused_v_rise = v_rise;

    // The hsync length check is armed exactly when the FSM has left SEARCH.
    assign meas       = sat_inc10(rec_x_q);
    assign x_sat      = (rec_x_q == CntMax);
    assign h_len_bad  = h_fall && (state_q != StSearch) && (meas != 10'(H_TOTAL));
    assign h_len_good = h_fall && (state_q != StSearch) && (meas == 10'(H_TOTAL));
    assign v_len_bad  = v_fall && v_armed_q && (vcnt_q != 10'(V_TOTAL));
    assign v_len_good = v_fall && v_armed_q && (vcnt_q == 10'(V_TOTAL));

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        unique case (state_q)
            StSearch: begin
                if (h_fall) begin
                    state_d    = StTrack;
                    lock_cnt_d = '0;
                end
            end
            StTrack: begin
                if (x_sat) begin
                    state_d = StSearch;
                end else if (h_len_bad) begin
                    lock_cnt_d = '0;
                end else if (h_len_good) begin
                    if (lock_cnt_q == LockW'(LOCK_LINES - 1)) begin
                        state_d = StLocked;
                    end else begin
                        lock_cnt_d = lock_cnt_q + LockW'(1);
                    end
                end
            end
            StLocked: begin
                if (x_sat || h_len_bad) begin
                    state_d = StSearch;
                end
            end
            default: state_d = StSearch;
        endcase
    end

    assign enter_search = (state_q != StSearch) && (state_d == StSearch);

    always_comb begin
        rec_y_d = rec_y_q;
        if (v_fall) begin
            rec_y_d = '0;
        end else if (h_fall && rec_y_q != LineMax) begin
            rec_y_d = rec_y_q + 9'd1;
        end

        width_d = width_q;
        if (h_fall) begin
            width_d = 10'd1;
        end else if (!vga_h_sync) begin
            width_d = sat_inc10(width_q);
        end

        // An hsync edge coinciding with vsync opens the new frame's count.
        vcnt_d = vcnt_q;
        if (v_fall) begin
            vcnt_d = h_fall ? 10'd1 : 10'd0;
        end else if (h_fall) begin
            vcnt_d = sat_inc10(vcnt_q);
        end

        v_armed_d = v_armed_q;
        if (enter_search) begin
            v_armed_d = 1'b0;
        end else if (v_fall) begin
            v_armed_d = 1'b1;
        end

        frame_ok_d = frame_ok_q;
        if (state_d != StLocked || v_len_bad) begin
            frame_ok_d = 1'b0;
        end else if (v_len_good && state_q == StLocked) begin
            frame_ok_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StSearch;
            lock_cnt_q    <= '0;
            rec_x_q       <= '0;
            rec_y_q       <= '0;
            line_len_q    <= '0;
            width_q       <= '0;
            vcnt_q        <= '0;
            v_armed_q     <= 1'b0;
            locked_q      <= 1'b0;
            frame_ok_q    <= 1'b0;
            h_len_err_q   <= 1'b0;
            h_width_err_q <= 1'b0;
            v_len_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            lock_cnt_q    <= lock_cnt_d;
            rec_x_q       <= h_fall ? 10'd0 : meas;
            rec_y_q       <= rec_y_d;
            line_len_q    <= h_fall ? meas : line_len_q;
            width_q       <= width_d;
            vcnt_q        <= vcnt_d;
            v_armed_q     <= v_armed_d;
            locked_q      <= (state_d == StLocked);
            frame_ok_q    <= frame_ok_d;
            h_len_err_q   <= h_len_bad;
            h_width_err_q <= h_rise && (width_q != 10'(H_PULSE));
            v_len_err_q   <= v_len_bad;
        end
    end

    assign rec_x       = rec_x_q;
    assign rec_y       = rec_y_q;
    assign line_len    = line_len_q;
    assign locked      = locked_q;
    assign frame_ok    = frame_ok_q;
    assign h_len_err   = h_len_err_q;
    assign h_width_err = h_width_err_q;
    assign v_len_err   = v_len_err_q;

endmodule
